e_mdu: RTL and testbench

- E-stage multiply/divide unit. Sits beside the ALU and feeds the M pipeline register.
- Executes mult/multu/div/divu/mthi/mtlo and holds the HI/LO register pair.
- Models multi-cycle latency with a busy counter.
- Drives a stall request into the D-stage hazard logic, so any HI/LO-using instruction in D waits while a product or quotient is pending.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_calc.sv | 55 +++++
 rtl/e_mdu.sv | 90 +++++++++
 tb/tb_e_mdu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings and default latencies for the E-stage MDU.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate ops).
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Opcodes that occupy the unit for a multi-cycle busy window.
  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU) ||
        (op == MDU_DIV)  || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
    return r;
  endfunction

  // Divide-class opcodes use the longer latency; everything else the multiply one.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit {hi,lo} result generator for mult/div
// (and madd/maddu when MDU_MADD_EN is defined).
import mdu_pkg::*;

module mdu_calc (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [32:0] sa33;
  logic signed [32:0] sb33;
  logic signed [32:0] sq33;
  logic signed [32:0] sr33;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic               div_unused;

  // Arithmetic datapaths; division runs at 33 bits so MIN_INT / -1 cannot overflow.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    b_safe = (b == 32'd0) ? 32'd1 : b;
    sa33   = $signed({a[31], a});
    sb33   = $signed({b_safe[31], b_safe});
    sq33   = sa33 / sb33;
    sr33   = sa33 % sb33;
    uq     = a / b_safe;
    ur     = a % b_safe;
    div_unused = sq33[32] ^ sr33[32];
  end

  // Select the result; a zero divisor reproduces the committed pair so commit is a no-op.
  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV:   res = (b == 32'd0) ? {hi, lo} : {sr33[31:0], sq33[31:0]};
      MDU_DIVU:  res = (b == 32'd0) ? {hi, lo} : {ur, uq};
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + prod_s;
      MDU_MADDU: res = {hi, lo} + prod_u;
`endif
      default:   res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit holding HI/LO with a busy countdown
// modelling multi-cycle latency. Optional feature macro: MDU_MADD_EN.
import mdu_pkg::*;

module e_mdu #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic [31:0] MDUIn1,
  input  logic [31:0] MDUIn2,
  input  logic        md_d,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_stall
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q,  cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q,   hi_d;
  logic [31:0] lo_q,   lo_d;
  logic [63:0] calc_res;
  logic        accept;

  mdu_calc u_calc (
    .op  (MDUOp),
    .a   (MDUIn1),
    .b   (MDUIn2),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res)
  );

  // Next-state: countdown/commit while busy, otherwise accept a long op or a HI/LO move.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    accept = start && !busy_q && is_long_op(MDUOp);
    if (busy_q) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        hi_d   = pend_q[63:32];
        lo_d   = pend_q[31:0];
      end
    end else if (accept) begin
      pend_d = calc_res;
      cnt_d  = is_div_op(MDUOp) ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
      busy_d = 1'b1;
    end else if (MDUOp == MDU_MTHI) begin
      hi_d = MDUIn1;
    end else if (MDUOp == MDU_MTLO) begin
      lo_d = MDUIn1;
    end
  end

  // State registers with synchronous reset that also aborts any pending operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= 5'd0;
      pend_q <= 64'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Outputs: committed registers plus the combinational D-stage stall request.
  always_comb begin
    busy     = busy_q;
    HI       = hi_q;
    LO       = lo_q;
    md_stall = md_d && (start || busy_q);
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu; expected {HI,LO} pushed at issue,
// popped and compared by a monitor when busy falls.
import mdu_pkg::*;

module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  MDUOp = MDU_NONE;
  logic        start = 1'b0;
  logic [31:0] MDUIn1 = 32'd0;
  logic [31:0] MDUIn2 = 32'd0;
  logic        md_d = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        md_stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .MDUOp    (MDUOp),
    .start    (start),
    .MDUIn1   (MDUIn1),
    .MDUIn2   (MDUIn2),
    .md_d     (md_d),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every busy 1->0 transition outside reset is a commit to score.
  initial begin : monitor
    logic prev_busy;
    logic [63:0] exp;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && prev_busy && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected actual=%h required=none", {HI, LO});
        end else begin
          exp = sb.pop_front();
          chk("commit_hilo", {HI, LO}, exp);
          $display("commit HI=%h LO=%h", HI, LO);
        end
      end
      prev_busy = busy;
    end
  end

  // Start while busy must never be presented by this bench.
  always @(posedge clk) begin
    if (!reset && start && busy) begin
      errors++;
      $display("FAIL start_while_busy actual=1 required=0");
    end
  end

  // Issue one long op, check the busy window, stall and HI/LO stability.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n, input logic md);
    @(negedge clk);
    MDUOp = op; start = 1'b1; MDUIn1 = a; MDUIn2 = b; md_d = md;
    sb.push_back({eh, el});
    $display("issue %s a=%h b=%h expect HI=%h LO=%h", nm, a, b, eh, el);
    #1 chk({nm, "_stall_start"}, 64'(md_stall), 64'(md));
    @(negedge clk);
    start = 1'b0; MDUOp = MDU_NONE;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk({nm, "_busy"}, 64'(busy), 64'd1);
      chk({nm, "_stall_busy"}, 64'(md_stall), 64'(md));
      chk({nm, "_hold"}, {HI, LO}, {hi_m, lo_m});
    end
    @(negedge clk);
    #1;
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_stall_idle"}, 64'(md_stall), 64'd0);
    hi_m = eh; lo_m = el;
  endtask

  // Move-to-HI/LO with a one-cycle op pulse.
  task automatic mt(input string nm, input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    MDUOp = op; MDUIn1 = v; md_d = 1'b0;
    @(negedge clk);
    MDUOp = MDU_NONE;
    if (op == MDU_MTHI) hi_m = v; else lo_m = v;
    $display("move %s value=%h", nm, v);
    #1 chk(nm, {HI, LO}, {hi_m, lo_m});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    reset = 1'b0;
    md_d = 1'b1;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hilo", {HI, LO}, 64'd0);
    chk("reset_stall", 64'(md_stall), 64'd0);

    run_op("mult",      MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b1);
    run_op("divu",      MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10, 1'b1);
    run_op("div_neg",   MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1);
    run_op("div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10, 1'b1);
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b1);
    run_op("mult_md0",  MDU_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5,  1'b0);

    mt("mthi", MDU_MTHI, 32'h12345678);
    mt("mtlo", MDU_MTLO, 32'h12345678);
    run_op("div_zero",  MDU_DIV,   32'd55,       32'd0,        32'h12345678, 32'h12345678, 10, 1'b1);
    mt("mtlo_abcd", MDU_MTLO, 32'h0000ABCD);

    // Reset in the third busy cycle of a mult aborts it without a commit.
    @(negedge clk);
    MDUOp = MDU_MULT; start = 1'b1; MDUIn1 = 32'd5; MDUIn2 = 32'd5; md_d = 1'b1;
    $display("issue mult_abort a=%h b=%h expect abort", MDUIn1, MDUIn2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0; MDUOp = MDU_NONE;
      #1 chk("abort_busy", 64'(busy), 64'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_late", {31'd0, busy, HI, LO}, 64'd0);
    end

    mt("mthi0", MDU_MTHI, 32'd0);
    mt("mtlo_ones", MDU_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MDU_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 1'b1);
`else
    @(negedge clk);
    MDUOp = MDU_MADDU; start = 1'b1; MDUIn1 = 32'd1; MDUIn2 = 32'd1; md_d = 1'b0;
    $display("issue maddu_disabled a=%h b=%h expect ignored", MDUIn1, MDUIn2);
    @(negedge clk);
    start = 1'b0; MDUOp = MDU_NONE;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("maddu_off_busy", 64'(busy), 64'd0);
      chk("maddu_off_hilo", {HI, LO}, {hi_m, lo_m});
      @(negedge clk);
    end
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
